// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package addsub_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned STAT_W = 16;

  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  int unsigned idx;

  // Scan requesters starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any_gnt && req[idx]) begin
        any_gnt     = 1'b1;
        gnt_idx     = ID_W'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_st.sv
// 8-bit add/subtract unit. {S3,S2}: 1x = arithmetic (S2=1 subtracts),
// 0x = transfer A. C is the raw carry out (1 = no borrow on subtract).
module addsub_st
  import addsub_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              s3,
  input  logic              s2,
  output logic [DATA_W-1:0] s,
  output logic              z,
  output logic              c,
  output logic              o
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  // Two's-complement add of A and (optionally inverted) B, then flag decode.
  always_comb begin
    b_eff = s2 ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + (DATA_W + 1)'(s2);
    s     = a;
    c     = 1'b0;
    o     = 1'b0;
    if (s3) begin
      s = sum[DATA_W-1:0];
      c = sum[DATA_W];
      o = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end
    z = (s == '0);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one addsub_st between NUM_REQ requesters with round-robin grant
// and a single registered, ID-tagged response channel.
// Optional grant statistics: define ADDSUB_ARB_STATS_EN.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_s,
  output logic                      rsp_z,
  output logic                      rsp_c,
  output logic                      rsp_o
`ifdef ADDSUB_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  input  logic [ID_W-1:0]           stat_sel,
  output logic [STAT_W-1:0]         stat_cnt
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_s_q, rsp_s_d;
  logic              rsp_z_q, rsp_z_d;
  logic              rsp_c_q, rsp_c_d;
  logic              rsp_o_q, rsp_o_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_gnt;
  int unsigned        sel;

  logic [DATA_W-1:0] alu_s;
  logic              alu_z, alu_c, alu_o;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // The shared unit sees only the captured operands.
  addsub_st u_addsub (
    .a  (a_q),
    .b  (b_q),
    .s3 (op_q[1]),
    .s2 (op_q[0]),
    .s  (alu_s),
    .z  (alu_z),
    .c  (alu_c),
    .o  (alu_o)
  );

  // Next-state, operand capture and response capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_z_d     = rsp_z_q;
    rsp_c_d     = rsp_c_q;
    rsp_o_d     = rsp_o_q;
    req_ready   = '0;
    sel         = 32'(gnt_idx);
    case (state_q)
      IDLE: begin
        req_ready = gnt_oh;
        if (any_gnt) begin
          a_d     = req_a[sel*DATA_W +: DATA_W];
          b_d     = req_b[sel*DATA_W +: DATA_W];
          op_d    = req_op[sel*2 +: 2];
          id_d    = gnt_idx;
          ptr_d   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_s_d     = alu_s;
        rsp_z_d     = alu_z;
        rsp_c_d     = alu_c;
        rsp_o_d     = alu_o;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_z_q     <= 1'b0;
      rsp_c_q     <= 1'b0;
      rsp_o_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_z_q     <= rsp_z_d;
      rsp_c_q     <= rsp_c_d;
      rsp_o_q     <= rsp_o_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_o     = rsp_o_q;

`ifdef ADDSUB_ARB_STATS_EN
  logic              hs;
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_W-1:0] cnt_d [NUM_REQ];

  assign hs = (state_q == IDLE) && any_gnt;

  // Saturating per-requester grant counters; clear has priority.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (hs && gnt_oh[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stat_cnt = (32'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : '0;
`endif

endmodule
